// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcode encodings and the
// PC source selector used by both the fetch datapath and the controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_HOLD   = 2'd3
  } pcsrc_e;

endpackage

// File: rtl/mips_flopenr.sv
// Width-parameterised register with synchronous reset to a chosen value and
// a load enable; reset wins over the enable.
module mips_flopenr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= RESET_VAL;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/mips_fetch.sv
// Fetch and state-holding datapath slice of the multicycle MIPS core: owns
// PC, IR, MDR and ALUOut and decodes instruction fields for the controller.
module mips_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iord,
  input  logic        irwrite,
  input  logic        pcwrite,
  input  logic        branch,
  input  logic        memwrite,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] b_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sext,
  output logic [31:0] mdr,
  output logic [31:0] aluout,
  output logic [31:0] fetch_count,
  output logic        pc_misaligned
);

  logic [31:0] pc_q, instr_q, mdr_q, aluout_q;
  logic [31:0] pcNext_d;
  logic [31:0] fetchCount_q;
  logic        pcMisaligned_q;
  logic        branchTake, pcEn;
  pcsrc_e      pcSel;

  assign pcSel = pcsrc_e'(pcsrc);

  // The controller folds BEQ and BNE into one branch state, so the polarity
  // of the zero flag is chosen here from the latched opcode.
  always_comb begin
    branchTake = 1'b0;
    case (instr_q[31:26])
      OP_BEQ:  branchTake = alu_zero;
      OP_BNE:  branchTake = ~alu_zero;
      default: branchTake = 1'b0;
    endcase
  end

  always_comb begin
    pcNext_d = pc_q;
    case (pcSel)
      PCSRC_ALU:    pcNext_d = alu_result;
      PCSRC_ALUOUT: pcNext_d = aluout_q;
      PCSRC_JUMP:   pcNext_d = {pc_q[31:28], instr_q[25:0], 2'b00};
      default:      pcNext_d = pc_q;
    endcase
  end

  assign pcEn = (pcwrite | (branch & branchTake)) & (pcSel != PCSRC_HOLD);

  mips_flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) uPc (
    .clk(clk), .reset(reset), .en(pcEn), .d(pcNext_d), .q(pc_q)
  );

  mips_flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) uIr (
    .clk(clk), .reset(reset), .en(irwrite), .d(mem_rdata), .q(instr_q)
  );

  mips_flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) uMdr (
    .clk(clk), .reset(reset), .en(1'b1), .d(mem_rdata), .q(mdr_q)
  );

  mips_flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) uAluOut (
    .clk(clk), .reset(reset), .en(1'b1), .d(alu_result), .q(aluout_q)
  );

  // Misalignment is sticky until reset; the offending load is not blocked.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchCount_q   <= 32'h0;
      pcMisaligned_q <= 1'b0;
    end else begin
      if (irwrite)
        fetchCount_q <= fetchCount_q + 32'd1;
      if (pcEn && (pcNext_d[1:0] != 2'b00))
        pcMisaligned_q <= 1'b1;
    end
  end

  assign mem_addr  = iord ? aluout_q : pc_q;
  assign mem_wdata = b_data;
  assign mem_we    = memwrite;

  assign pc            = pc_q;
  assign instr         = instr_q;
  assign mdr           = mdr_q;
  assign aluout        = aluout_q;
  assign fetch_count   = fetchCount_q;
  assign pc_misaligned = pcMisaligned_q;

  assign opcode   = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign funct    = instr_q[5:0];
  assign imm_sext = {{16{instr_q[15]}}, instr_q[15:0]};

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch: hand-computed expectations for reset,
// fetch, branch polarity, jump, loads, misalignment and mid-op reset.
module tb_mips_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        iord, irwrite, pcwrite, branch, memwrite;
  logic [1:0]  pcsrc;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] b_data, mem_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [31:0] pc, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, mdr, aluout, fetch_count;
  logic        pc_misaligned;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_fetch #(.RESET_PC(32'h40)) dut (
    .clk(clk), .reset(reset), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .memwrite(memwrite), .pcsrc(pcsrc),
    .alu_result(alu_result), .alu_zero(alu_zero), .b_data(b_data),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .pc(pc), .instr(instr), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .imm_sext(imm_sext), .mdr(mdr),
    .aluout(aluout), .fetch_count(fetch_count), .pc_misaligned(pc_misaligned)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle just after it, where outputs are sampled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setCtl(input logic i, input logic irw, input logic pcw,
                        input logic br, input logic [1:0] src);
    iord = i; irwrite = irw; pcwrite = pcw; branch = br; pcsrc = src;
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; alu_zero = 1'b0;
    b_data = 32'h0; mem_rdata = 32'h0; alu_result = 32'h0;
    setCtl(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("rst_pc", pc, 32'h40);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_fcount", fetch_count, 32'h0);
    checkOutput("rst_misal", {31'h0, pc_misaligned}, 32'h0);
    checkOutput("rst_addr", mem_addr, 32'h40);
    checkOutput("rst_opcode", {26'h0, opcode}, 32'h0);
    checkOutput("rst_imm", imm_sext, 32'h0);
    memwrite = 1'b1; b_data = 32'h1234_5678;
    #1;
    checkOutput("rst_we", {31'h0, mem_we}, 32'h1);
    checkOutput("rst_wdata", mem_wdata, 32'h1234_5678);
    memwrite = 1'b0;

    // Fetch: IR <- mem[pc], PC <- pc+4 on one edge.
    reset = 1'b0;
    mem_rdata = 32'h8C08_0004; alu_result = 32'h44;
    setCtl(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    applyStimulus();
    checkOutput("f_instr", instr, 32'h8C08_0004);
    checkOutput("f_opcode", {26'h0, opcode}, 32'h23);
    checkOutput("f_rt", {27'h0, rt}, 32'h8);
    checkOutput("f_imm", imm_sext, 32'h4);
    checkOutput("f_pc", pc, 32'h44);
    checkOutput("f_fcount", fetch_count, 32'h1);
    checkOutput("f_mdr", mdr, 32'h8C08_0004);
    checkOutput("f_aluout", aluout, 32'h44);
    checkOutput("f_addr", mem_addr, 32'h44);

    // Load BEQ into IR, target 0x54 into ALUOut.
    mem_rdata = 32'h1000_0003; alu_result = 32'h54;
    setCtl(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    applyStimulus();
    checkOutput("beq_ir", instr, 32'h1000_0003);
    checkOutput("beq_fcount", fetch_count, 32'h2);
    checkOutput("beq_pc_hold", pc, 32'h44);

    setCtl(1'b0, 1'b0, 1'b0, 1'b1, 2'd1); alu_zero = 1'b0;
    applyStimulus();
    checkOutput("beq_nt_pc", pc, 32'h44);
    alu_zero = 1'b1;
    applyStimulus();
    checkOutput("beq_t_pc", pc, 32'h54);

    // Move PC away, load BNE into IR.
    alu_result = 32'h60; mem_rdata = 32'h1400_0003;
    setCtl(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    applyStimulus();
    checkOutput("bne_setup_pc", pc, 32'h60);
    alu_result = 32'h54;
    setCtl(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus();
    setCtl(1'b0, 1'b0, 1'b0, 1'b1, 2'd1); alu_zero = 1'b1;
    applyStimulus();
    checkOutput("bne_nt_pc", pc, 32'h60);
    alu_zero = 1'b0;
    applyStimulus();
    checkOutput("bne_t_pc", pc, 32'h54);

    setCtl(1'b0, 1'b0, 1'b1, 1'b0, 2'd3); alu_result = 32'h88;
    applyStimulus();
    checkOutput("hold_pc", pc, 32'h54);

    // Jump: PC region bits kept from current PC.
    alu_result = 32'h4000_0008; mem_rdata = 32'h0800_0010;
    setCtl(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    applyStimulus();
    setCtl(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    applyStimulus();
    checkOutput("j_pc", pc, 32'h4000_0040);
    setCtl(1'b0, 1'b0, 1'b0, 1'b1, 2'd1); alu_zero = 1'b1;
    applyStimulus();
    checkOutput("nonbr_pc", pc, 32'h4000_0040);

    // Data load through ALUOut address.
    alu_result = 32'h100;
    setCtl(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus();
    checkOutput("ld_addr", mem_addr, 32'h100);
    mem_rdata = 32'hDEAD_BEEF;
    applyStimulus();
    checkOutput("ld_mdr", mdr, 32'hDEAD_BEEF);
    checkOutput("ld_ir_keep", instr, 32'h0800_0010);
    checkOutput("ld_opcode", {26'h0, opcode}, 32'h2);
    memwrite = 1'b1; b_data = 32'h0000_CAFE;
    #1;
    checkOutput("st_we", {31'h0, mem_we}, 32'h1);
    checkOutput("st_wdata", mem_wdata, 32'h0000_CAFE);
    memwrite = 1'b0;

    // Misaligned PC load is performed and sticks.
    alu_result = 32'h46;
    setCtl(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    applyStimulus();
    checkOutput("mis_pc", pc, 32'h46);
    checkOutput("mis_flag", {31'h0, pc_misaligned}, 32'h1);
    alu_result = 32'h48;
    applyStimulus();
    checkOutput("mis_pc2", pc, 32'h48);
    checkOutput("mis_sticky", {31'h0, pc_misaligned}, 32'h1);

    // Reset overrides enables on the same edge.
    reset = 1'b1; mem_rdata = 32'h1234_5678; memwrite = 1'b1;
    setCtl(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    #1;
    checkOutput("rst_we_mid", {31'h0, mem_we}, 32'h1);
    applyStimulus();
    checkOutput("mrst_instr", instr, 32'h0);
    checkOutput("mrst_pc", pc, 32'h40);
    checkOutput("mrst_misal", {31'h0, pc_misaligned}, 32'h0);
    checkOutput("mrst_fcount", fetch_count, 32'h0);
    checkOutput("mrst_mdr", mdr, 32'h0);

    // R-type field decode and negative immediate.
    reset = 1'b0; memwrite = 1'b0; mem_rdata = 32'h012A_4020;
    setCtl(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    applyStimulus();
    checkOutput("r_rs", {27'h0, rs}, 32'h9);
    checkOutput("r_rt", {27'h0, rt}, 32'hA);
    checkOutput("r_rd", {27'h0, rd}, 32'h8);
    checkOutput("r_funct", {26'h0, funct}, 32'h20);
    mem_rdata = 32'h8C08_FFFC;
    applyStimulus();
    checkOutput("neg_imm", imm_sext, 32'hFFFF_FFFC);
    checkOutput("neg_fcount", fetch_count, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch.md
# mips_fetch

Instruction-fetch and state-holding datapath slice for the multicycle MIPS core, sitting between unified memory and the main control FSM. It owns the PC, instruction register (IR), memory data register (MDR) and ALUOut register. It drives the memory address and decodes opcode/funct fields back to the controller. It applies the controller's IorD, IRWrite, PCWrite, Branch, PCSrc and MemWrite strobes, including BEQ/BNE polarity, which the controller merges into one branch state.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  single clock; all state on posedge
- reset  in  1  synchronous, active-high
- iord  in  1  0: mem_addr = pc; 1: mem_addr = aluout
- irwrite  in  1  load IR from mem_rdata
- pcwrite  in  1  unconditional PC load
- branch  in  1  conditional PC load (branch state)
- memwrite  in  1  store strobe, forwarded to mem_we
- pcsrc  in  2  PC source select
- alu_result  in  32  combinational ALU output
- alu_zero  in  1  ALU zero flag
- b_data  in  32  rt register value (store data)
- mem_rdata  in  32  memory read data (combinational read)
- mem_addr  out  32  memory address
- mem_wdata  out  32  = b_data
- mem_we  out  1  = memwrite
- pc  out  32  current PC
- instr  out  32  IR contents
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- imm_sext  out  32  sign-extended instr[15:0]
- mdr  out  32  MDR contents
- aluout  out  32  ALUOut register
- fetch_count  out  32  IR loads since reset
- pc_misaligned  out  1  sticky: PC loaded with nonzero [1:0]

## Operation
- Next PC by pcsrc:
  - 0: alu_result (PC+4 in fetch state)
  - 1: aluout (branch target computed in decode state)
  - 2: {pc[31:28], instr[25:0], 2'b00} (jump)
  - 3: hold current PC, no load
- Branch condition:
  - opcode 000100 (BEQ): take = alu_zero
  - opcode 000101 (BNE): take = ~alu_zero
  - any other opcode: take = 0
- pc_en = pcwrite | (branch & take). Both asserted together: single load, same source.
- IR loads mem_rdata when irwrite; otherwise holds. fetch_count increments on each IR load and wraps 2^32-1 -> 0.
- MDR loads mem_rdata every cycle. ALUOut loads alu_result every cycle.
- pc_misaligned sets when pc_en loads a value with [1:0] != 0. It stays set until reset. The load itself still happens.
- Field outputs and imm_sext are combinational from IR only, never from mem_rdata.

## Timing
- Reset values: pc = RESET_PC; instr, mdr, aluout, fetch_count = 0; pc_misaligned = 0. With instr = 0, opcode = funct = 0 and imm_sext = 0.
- mem_addr, mem_we and mem_wdata are combinational, with zero latency from iord, memwrite and b_data.
- PC, IR, MDR and ALUOut update one edge after their enables. Values are visible in the following cycle.
- The controller's fetch state (irwrite, pcwrite, pcsrc=0) loads IR with mem[pc] and PC with pc+4 on the same edge. IR latches using the pre-edge pc.
- Reset asserted mid-instruction takes priority over every enable on that edge. Memory stores are not masked: mem_we follows memwrite even during reset.
- A branch-not-taken cycle leaves PC unchanged.

## Structure
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_BNE 000101, OP_ADDI 001000, OP_J 000010
  - pcsrc enum: PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_HOLD
- The same package is used by the controller.
- One sub-module: mips_flopenr, a WIDTH-parameterised register with sync reset, enable and reset value. It is instantiated for PC, IR, MDR and ALUOut.

## Test plan
- Reset: hold reset 2 cycles with RESET_PC=32'h40 -> pc=32'h40, instr=0, fetch_count=0, pc_misaligned=0, mem_addr=32'h40.
- Fetch: mem_rdata=32'h8C08_0004, irwrite=pcwrite=1, pcsrc=0, alu_result=32'h44 -> next cycle instr=32'h8C08_0004, opcode=100011, rt=8, imm_sext=4, pc=32'h44, fetch_count=1.
- BEQ/BNE: IR=32'h1000_0003, aluout=32'h54, branch=1, pcsrc=1.
  - BEQ, alu_zero=1 -> pc=32'h54.
  - BEQ, alu_zero=0 -> pc unchanged.
  - IR=32'h1400_0003 (BNE), alu_zero=0 -> pc=32'h54.
- Jump and load: IR=32'h0800_0010, pc=32'h4000_0008, pcwrite=1, pcsrc=2 -> pc=32'h4000_0040. Then iord=1, aluout=32'h100, mem_rdata=32'hDEAD_BEEF -> mem_addr=32'h100, mdr=32'hDEAD_BEEF next cycle.
- Misalignment and mid-op reset:
  - pcwrite=1, alu_result=32'h46 -> pc=32'h46, pc_misaligned=1, which stays 1 across later writes.
  - Reset with irwrite=1 on the same edge -> instr=0, pc=RESET_PC, pc_misaligned=0.
